// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage and register file.
// Holds the write-back source select encodings and default datapath widths.
package wb_pkg;

  localparam int WB_DATA_W  = 16;
  localparam int WB_ADDR_W  = 3;
  localparam int WB_COUNT_W = 16;

  // Mem_To_Reg encodings from the MEM/WB pipeline register.
  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_PC   = 2'b10,
    MTR_RSVD = 2'b11
  } mtr_e;

endpackage

// File: rtl/regfile_core.sv
// regfile_core: 2^ADDR_W x DATA_W architectural register file.
//   clk, rst_n            : clock, asynchronous active-low reset (clears all regs)
//   wr_en/wr_addr/wr_data : single write port, applied on rising edge
//   rd_addr_k/rd_data_k   : two combinational read ports with same-cycle write bypass
//   dbg_addr/dbg_data     : combinational debug read port, stored values only
// R0 has no storage and always reads as zero.
module regfile_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_word [NUM_REGS];
  logic              bypass_1;
  logic              bypass_2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_word[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] word_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_reg <= '0;
          end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
            word_reg <= wr_data;
          end
        end
        assign rf_word[gi] = word_reg;
      end
    end
  endgenerate

  // Bypass is held off during reset so the read ports present the cleared
  // state rather than an in-flight write that will never land.
  assign bypass_1 = rst_n && wr_en && (wr_addr != '0) && (rd_addr_1 == wr_addr);
  assign bypass_2 = rst_n && wr_en && (wr_addr != '0) && (rd_addr_2 == wr_addr);

  assign rd_data_1 = bypass_1 ? wr_data : rf_word[rd_addr_1];
  assign rd_data_2 = bypass_2 ? wr_data : rf_word[rd_addr_2];
  assign dbg_data  = rf_word[dbg_addr];

endmodule

// File: rtl/write_back_regfile.sv
// write_back_regfile: write-back stage plus register file.
//   clk, Reset_n          : clock, asynchronous active-low reset
//   Enable                : 0 stalls the stage, nothing commits or updates
//   Reg_Write_In, Mem_To_Reg_In, PC_Adder_In, ALU_Result_In, Read_Data_In,
//   Write_Reg_In          : MEM/WB pipeline register outputs
//   Read_Reg_k/Read_Data_k: ID-stage read ports (bypassed)
//   Debug_Reg_Sel/Data    : debug read port (stored values only)
//   Write_Data_Out        : selected write-back value, forwarding source
//   Write_Commit          : a write lands at the next rising edge
//   Write_Count           : wrapping count of committed writes
//   Sel_Error             : sticky, reserved Mem_To_Reg seen with a write request
module write_back_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int COUNT_W = WB_COUNT_W
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic               Reg_Write_In,
  input  logic [1:0]         Mem_To_Reg_In,
  input  logic [DATA_W-1:0]  PC_Adder_In,
  input  logic [DATA_W-1:0]  ALU_Result_In,
  input  logic [DATA_W-1:0]  Read_Data_In,
  input  logic [ADDR_W-1:0]  Write_Reg_In,
  input  logic [ADDR_W-1:0]  Read_Reg_1,
  input  logic [ADDR_W-1:0]  Read_Reg_2,
  output logic [DATA_W-1:0]  Read_Data_1,
  output logic [DATA_W-1:0]  Read_Data_2,
  input  logic [ADDR_W-1:0]  Debug_Reg_Sel,
  output logic [DATA_W-1:0]  Debug_Reg_Data,
  output logic [DATA_W-1:0]  Write_Data_Out,
  output logic               Write_Commit,
  output logic [COUNT_W-1:0] Write_Count,
  output logic               Sel_Error
);

  logic [DATA_W-1:0]  wb_data;
  logic               wr_req;
  logic               sel_rsvd;
  logic               commit;
  logic [COUNT_W-1:0] count_reg;
  logic               sel_error_reg;

  always_comb begin
    wb_data = '0;
    case (Mem_To_Reg_In)
      MTR_ALU: wb_data = ALU_Result_In;
      MTR_MEM: wb_data = Read_Data_In;
      MTR_PC:  wb_data = PC_Adder_In;
      default: wb_data = '0;
    endcase
  end

  assign wr_req   = Enable && Reg_Write_In;
  assign sel_rsvd = (Mem_To_Reg_In == MTR_RSVD);
  // R0 writes and reserved selects are dropped here so they are neither
  // stored, bypassed nor counted.
  assign commit   = wr_req && (Write_Reg_In != '0) && !sel_rsvd;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= '0;
    end else if (commit) begin
      count_reg <= count_reg + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_error_reg <= 1'b0;
    end else if (wr_req && sel_rsvd) begin
      sel_error_reg <= 1'b1;
    end
  end

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile_core (
    .clk       (clk),
    .rst_n     (Reset_n),
    .wr_en     (commit),
    .wr_addr   (Write_Reg_In),
    .wr_data   (wb_data),
    .rd_addr_1 (Read_Reg_1),
    .rd_addr_2 (Read_Reg_2),
    .rd_data_1 (Read_Data_1),
    .rd_data_2 (Read_Data_2),
    .dbg_addr  (Debug_Reg_Sel),
    .dbg_data  (Debug_Reg_Data)
  );

  assign Write_Data_Out = wb_data;
  assign Write_Commit   = commit;
  assign Write_Count    = count_reg;
  assign Sel_Error      = sel_error_reg;

endmodule

// File: tb/tb_write_back_regfile.sv
module tb_write_back_regfile;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic        Reg_Write_In;
  logic [1:0]  Mem_To_Reg_In;
  logic [15:0] PC_Adder_In;
  logic [15:0] ALU_Result_In;
  logic [15:0] Read_Data_In;
  logic [2:0]  Write_Reg_In;
  logic [2:0]  Read_Reg_1;
  logic [2:0]  Read_Reg_2;
  logic [15:0] Read_Data_1;
  logic [15:0] Read_Data_2;
  logic [2:0]  Debug_Reg_Sel;
  logic [15:0] Debug_Reg_Data;
  logic [15:0] Write_Data_Out;
  logic        Write_Commit;
  logic [15:0] Write_Count;
  logic        Sel_Error;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  write_back_regfile dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .Enable         (Enable),
    .Reg_Write_In   (Reg_Write_In),
    .Mem_To_Reg_In  (Mem_To_Reg_In),
    .PC_Adder_In    (PC_Adder_In),
    .ALU_Result_In  (ALU_Result_In),
    .Read_Data_In   (Read_Data_In),
    .Write_Reg_In   (Write_Reg_In),
    .Read_Reg_1     (Read_Reg_1),
    .Read_Reg_2     (Read_Reg_2),
    .Read_Data_1    (Read_Data_1),
    .Read_Data_2    (Read_Data_2),
    .Debug_Reg_Sel  (Debug_Reg_Sel),
    .Debug_Reg_Data (Debug_Reg_Data),
    .Write_Data_Out (Write_Data_Out),
    .Write_Commit   (Write_Commit),
    .Write_Count    (Write_Count),
    .Sel_Error      (Sel_Error)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  task automatic drive_idle();
    Enable = 1'b1; Reg_Write_In = 1'b0; Mem_To_Reg_In = 2'b00;
    PC_Adder_In = 16'h0; ALU_Result_In = 16'h0; Read_Data_In = 16'h0;
    Write_Reg_In = 3'd0; Read_Reg_1 = 3'd0; Read_Reg_2 = 3'd0; Debug_Reg_Sel = 3'd0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive_idle();
    Reg_Write_In = 1'b1; ALU_Result_In = 16'h9999; Write_Reg_In = 3'd5; Read_Reg_1 = 3'd5;
    #1;
    checks++; if (Read_Data_1 !== 16'h0) begin errors++; $display("FAIL rst_no_bypass: got %h need %h", Read_Data_1, 16'h0); end
    checks++; if (Write_Commit !== 1'b1) begin errors++; $display("FAIL rst_commit_comb: got %b need 1", Write_Commit); end
    checks++; if (Write_Data_Out !== 16'h9999) begin errors++; $display("FAIL rst_mux_comb: got %h need 9999", Write_Data_Out); end
    @(posedge clk); #1;
    Debug_Reg_Sel = 3'd5; #1;
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL rst_no_write: got %h need 0000", Debug_Reg_Data); end
    $display("txn reset: held with pending write to R5");
    drive_idle();
    @(negedge clk); Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Read_Reg_1 = 3'(i); Read_Reg_2 = 3'(7 - i); Debug_Reg_Sel = 3'(i); #1;
      checks++; if (Read_Data_1 !== 16'h0) begin errors++; $display("FAIL rst_rd1 R%0d: got %h need 0000", i, Read_Data_1); end
      checks++; if (Read_Data_2 !== 16'h0) begin errors++; $display("FAIL rst_rd2 R%0d: got %h need 0000", 7 - i, Read_Data_2); end
      checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL rst_dbg R%0d: got %h need 0000", i, Debug_Reg_Data); end
    end
    checks++; if (Write_Count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h need 0000", Write_Count); end
    checks++; if (Sel_Error !== 1'b0) begin errors++; $display("FAIL rst_sel_error: got %b need 0", Sel_Error); end
    $display("txn reset: released, all regs read back");
  endtask

  task automatic test_mem_write();
    @(posedge clk); #1;
    Enable = 1'b1; Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b01; Read_Data_In = 16'hBEEF;
    ALU_Result_In = 16'h1111; PC_Adder_In = 16'h2222;
    Write_Reg_In = 3'd3; Read_Reg_1 = 3'd3; Read_Reg_2 = 3'd3; Debug_Reg_Sel = 3'd3; #1;
    checks++; if (Write_Data_Out !== 16'hBEEF) begin errors++; $display("FAIL mem_mux: got %h need beef", Write_Data_Out); end
    checks++; if (Write_Commit !== 1'b1) begin errors++; $display("FAIL mem_commit: got %b need 1", Write_Commit); end
    checks++; if (Read_Data_1 !== 16'hBEEF) begin errors++; $display("FAIL mem_bypass_rd1: got %h need beef", Read_Data_1); end
    checks++; if (Read_Data_2 !== 16'hBEEF) begin errors++; $display("FAIL mem_bypass_rd2: got %h need beef", Read_Data_2); end
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL mem_dbg_nobypass: got %h need 0000", Debug_Reg_Data); end
    @(posedge clk); #1;
    exp_count++;
    drive_idle(); Read_Reg_1 = 3'd3; Debug_Reg_Sel = 3'd3; #1;
    checks++; if (Debug_Reg_Data !== 16'hBEEF) begin errors++; $display("FAIL mem_stored: got %h need beef", Debug_Reg_Data); end
    checks++; if (Read_Data_1 !== 16'hBEEF) begin errors++; $display("FAIL mem_rd_stored: got %h need beef", Read_Data_1); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL mem_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn mem_write: R3 <= beef");
  endtask

  task automatic test_alu_write();
    @(posedge clk); #1;
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'h1357; Read_Data_In = 16'hBEEF;
    Write_Reg_In = 3'd1; Read_Reg_1 = 3'd1; Read_Reg_2 = 3'd3; #1;
    checks++; if (Write_Data_Out !== 16'h1357) begin errors++; $display("FAIL alu_mux: got %h need 1357", Write_Data_Out); end
    checks++; if (Read_Data_1 !== 16'h1357) begin errors++; $display("FAIL alu_bypass: got %h need 1357", Read_Data_1); end
    checks++; if (Read_Data_2 !== 16'hBEEF) begin errors++; $display("FAIL alu_other_port: got %h need beef", Read_Data_2); end
    @(posedge clk); #1;
    exp_count++;
    drive_idle(); Debug_Reg_Sel = 3'd1; #1;
    checks++; if (Debug_Reg_Data !== 16'h1357) begin errors++; $display("FAIL alu_stored: got %h need 1357", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL alu_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn alu_write: R1 <= 1357");
  endtask

  task automatic test_jal_and_r0();
    @(posedge clk); #1;
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b10; PC_Adder_In = 16'h0042; ALU_Result_In = 16'hDEAD;
    Write_Reg_In = 3'd7; Read_Reg_2 = 3'd7; #1;
    checks++; if (Write_Data_Out !== 16'h0042) begin errors++; $display("FAIL jal_mux: got %h need 0042", Write_Data_Out); end
    checks++; if (Read_Data_2 !== 16'h0042) begin errors++; $display("FAIL jal_bypass: got %h need 0042", Read_Data_2); end
    @(posedge clk); #1;
    exp_count++;
    drive_idle(); Debug_Reg_Sel = 3'd7; #1;
    checks++; if (Debug_Reg_Data !== 16'h0042) begin errors++; $display("FAIL jal_stored: got %h need 0042", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL jal_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn jal: R7 <= 0042");
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'h1234;
    Write_Reg_In = 3'd0; Read_Reg_1 = 3'd0; Debug_Reg_Sel = 3'd0; #1;
    checks++; if (Write_Commit !== 1'b0) begin errors++; $display("FAIL r0_commit: got %b need 0", Write_Commit); end
    checks++; if (Write_Data_Out !== 16'h1234) begin errors++; $display("FAIL r0_mux: got %h need 1234", Write_Data_Out); end
    checks++; if (Read_Data_1 !== 16'h0) begin errors++; $display("FAIL r0_bypass: got %h need 0000", Read_Data_1); end
    @(posedge clk); #1;
    drive_idle(); Debug_Reg_Sel = 3'd0; #1;
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL r0_stored: got %h need 0000", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL r0_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn r0_write: 1234 discarded");
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    Enable = 1'b0; Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'h5555;
    Write_Reg_In = 3'd2; Read_Reg_1 = 3'd2; Debug_Reg_Sel = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (Write_Commit !== 1'b0) begin errors++; $display("FAIL stall_commit c%0d: got %b need 0", c, Write_Commit); end
      checks++; if (Read_Data_1 !== 16'h0) begin errors++; $display("FAIL stall_bypass c%0d: got %h need 0000", c, Read_Data_1); end
      @(posedge clk); #1;
      $display("txn stall: cycle %0d held", c);
    end
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL stall_r2: got %h need 0000", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL stall_count: got %h need %h", Write_Count, 16'(exp_count)); end
    Enable = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    drive_idle(); Debug_Reg_Sel = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Debug_Reg_Data !== 16'h5555) begin errors++; $display("FAIL unstall_r2: got %h need 5555", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL unstall_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn unstall: R2 <= 5555 once");
  endtask

  task automatic test_reserved();
    @(posedge clk); #1;
    Enable = 1'b0; Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b11; ALU_Result_In = 16'h7777;
    Write_Reg_In = 3'd4; Debug_Reg_Sel = 3'd4;
    @(posedge clk); #1;
    checks++; if (Sel_Error !== 1'b0) begin errors++; $display("FAIL rsvd_stalled: got %b need 0", Sel_Error); end
    Enable = 1'b1; #1;
    checks++; if (Write_Data_Out !== 16'h0) begin errors++; $display("FAIL rsvd_mux: got %h need 0000", Write_Data_Out); end
    checks++; if (Write_Commit !== 1'b0) begin errors++; $display("FAIL rsvd_commit: got %b need 0", Write_Commit); end
    checks++; if (Sel_Error !== 1'b0) begin errors++; $display("FAIL rsvd_early: got %b need 0", Sel_Error); end
    @(posedge clk); #1;
    drive_idle(); Debug_Reg_Sel = 3'd4; #1;
    checks++; if (Sel_Error !== 1'b1) begin errors++; $display("FAIL rsvd_set: got %b need 1", Sel_Error); end
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL rsvd_r4: got %h need 0000", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL rsvd_count: got %h need %h", Write_Count, 16'(exp_count)); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Sel_Error !== 1'b1) begin errors++; $display("FAIL rsvd_sticky: got %b need 1", Sel_Error); end
    $display("txn reserved: R4 untouched, Sel_Error sticky");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'h1111; Write_Reg_In = 3'd6;
    @(posedge clk); #1;
    exp_count++;
    ALU_Result_In = 16'h2222; Read_Reg_1 = 3'd6; Debug_Reg_Sel = 3'd6; #1;
    checks++; if (Read_Data_1 !== 16'h2222) begin errors++; $display("FAIL b2b_bypass: got %h need 2222", Read_Data_1); end
    checks++; if (Debug_Reg_Data !== 16'h1111) begin errors++; $display("FAIL b2b_first: got %h need 1111", Debug_Reg_Data); end
    @(posedge clk); #1;
    exp_count++;
    drive_idle(); Debug_Reg_Sel = 3'd6; #1;
    checks++; if (Debug_Reg_Data !== 16'h2222) begin errors++; $display("FAIL b2b_second: got %h need 2222", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count: got %h need %h", Write_Count, 16'(exp_count)); end
    $display("txn back_to_back: R6 <= 1111 then 2222");
  endtask

  task automatic test_wrap();
    int n;
    n = 65535 - exp_count;
    @(posedge clk); #1;
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'hA5A5; Write_Reg_In = 3'd5;
    repeat (n) @(posedge clk);
    #1;
    drive_idle(); Debug_Reg_Sel = 3'd5; #1;
    checks++; if (Write_Count !== 16'hFFFF) begin errors++; $display("FAIL wrap_full: got %h need ffff", Write_Count); end
    checks++; if (Debug_Reg_Data !== 16'hA5A5) begin errors++; $display("FAIL wrap_r5: got %h need a5a5", Debug_Reg_Data); end
    $display("txn wrap: %0d commits to R5", n);
    Reg_Write_In = 1'b1; ALU_Result_In = 16'h0F0F; Write_Reg_In = 3'd5;
    @(posedge clk); #1;
    drive_idle(); Debug_Reg_Sel = 3'd5; #1;
    checks++; if (Write_Count !== 16'h0) begin errors++; $display("FAIL wrap_zero: got %h need 0000", Write_Count); end
    checks++; if (Debug_Reg_Data !== 16'h0F0F) begin errors++; $display("FAIL wrap_r5_last: got %h need 0f0f", Debug_Reg_Data); end
    Reg_Write_In = 1'b1; ALU_Result_In = 16'h3C3C; Write_Reg_In = 3'd1;
    @(posedge clk); #1;
    drive_idle(); #1;
    checks++; if (Write_Count !== 16'h1) begin errors++; $display("FAIL wrap_one: got %h need 0001", Write_Count); end
    $display("txn wrap: counter rolled over");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    Reg_Write_In = 1'b1; Mem_To_Reg_In = 2'b00; ALU_Result_In = 16'h7E7E;
    Write_Reg_In = 3'd6; Read_Reg_1 = 3'd6; Read_Reg_2 = 3'd1; Debug_Reg_Sel = 3'd7; #1;
    checks++; if (Read_Data_1 !== 16'h7E7E) begin errors++; $display("FAIL mid_pre_bypass: got %h need 7e7e", Read_Data_1); end
    checks++; if (Debug_Reg_Data !== 16'h0042) begin errors++; $display("FAIL mid_pre_r7: got %h need 0042", Debug_Reg_Data); end
    #1; Reset_n = 1'b0; #1;
    checks++; if (Read_Data_1 !== 16'h0) begin errors++; $display("FAIL mid_rd1: got %h need 0000", Read_Data_1); end
    checks++; if (Read_Data_2 !== 16'h0) begin errors++; $display("FAIL mid_rd2: got %h need 0000", Read_Data_2); end
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL mid_r7: got %h need 0000", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'h0) begin errors++; $display("FAIL mid_count: got %h need 0000", Write_Count); end
    checks++; if (Sel_Error !== 1'b0) begin errors++; $display("FAIL mid_sel_error: got %b need 0", Sel_Error); end
    @(posedge clk); #1;
    drive_idle(); Debug_Reg_Sel = 3'd6;
    @(negedge clk); Reset_n = 1'b1; #1;
    checks++; if (Debug_Reg_Data !== 16'h0) begin errors++; $display("FAIL mid_write_lost: got %h need 0000", Debug_Reg_Data); end
    checks++; if (Write_Count !== 16'h0) begin errors++; $display("FAIL mid_count_after: got %h need 0000", Write_Count); end
    $display("txn reset_mid: state cleared, pending R6 write lost");
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_alu_write();
    test_jal_and_r0();
    test_stall();
    test_reserved();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
